// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
// Control bits travel as one packed struct so every stage register uses the same layout.
package hazard_pkg;

    localparam int REG_AW_DEF = 4;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic PCSrc;
        logic Branch;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: one cycle latency, clr beats en.
// No backpressure of its own; en=0 holds, clr=1 inserts an all-zero bubble.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Carries register addresses and control bits D->E->M->W; produces match/pending flags for the hazard unit.
// Latency 1/2/3 cycles to E/M/W; StallD freezes only external D, FlushE bubbles E; saturating perf counters.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA3D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              PCSrcD,
    input  logic              BranchD,
    input  logic              CondExE,
    input  logic              StallD,
    input  logic              FlushE,
    output logic              Match_1E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_M,
    output logic              Match_2E_W,
    output logic              Match_3E_M,
    output logic              Match_3E_W,
    output logic              Match_12D_E,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegE,
    output logic              PCSrcW,
    output logic              BranchTakenE,
    output logic              PCWrPendingF,
    output logic [REG_AW-1:0] WA3M,
    output logic [REG_AW-1:0] WA3W,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int EW = 4*REG_AW + $bits(stage_ctrl_t);
    localparam int MW = REG_AW + 3;
    localparam int WW = REG_AW + 2;

    stage_ctrl_t       w_ctrl_d;
    stage_ctrl_t       w_ctrl_e;
    logic [REG_AW-1:0] w_ra1e, w_ra2e, w_ra3e, w_wa3e;
    logic [EW-1:0]     w_e_d, w_e_q;
    logic [MW-1:0]     w_m_d, w_m_q;
    logic [WW-1:0]     w_w_d, w_w_q;
    logic              w_memtoreg_m;
    logic              w_pcsrc_m;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_ctrl_d = '{RegWrite: RegWriteD, MemtoReg: MemtoRegD, PCSrc: PCSrcD, Branch: BranchD};
    assign w_e_d    = {RA1D, RA2D, RA3D, WA3D, w_ctrl_d};

    // StallD deliberately does not gate E: the stall only holds the D latch upstream.
    pipe_stage_reg #(.W(EW)) u_stage_e (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (w_e_d),
        .q     (w_e_q)
    );

    assign {w_ra1e, w_ra2e, w_ra3e, w_wa3e, w_ctrl_e} = w_e_q;

    // A failed condition turns the instruction into a bubble from M onward.
    assign w_m_d = {w_wa3e,
                    w_ctrl_e.RegWrite & CondExE,
                    w_ctrl_e.MemtoReg & CondExE,
                    w_ctrl_e.PCSrc    & CondExE};

    pipe_stage_reg #(.W(MW)) u_stage_m (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (w_m_d),
        .q     (w_m_q)
    );

    assign {WA3M, RegWriteM, w_memtoreg_m, w_pcsrc_m} = w_m_q;
    assign w_w_d = {WA3M, RegWriteM, w_pcsrc_m};

    pipe_stage_reg #(.W(WW)) u_stage_w (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (w_w_d),
        .q     (w_w_q)
    );

    assign {WA3W, RegWriteW, PCSrcW} = w_w_q;

    // Raw address compares; write-enable qualification happens in the hazard unit.
    assign Match_1E_M  = (w_ra1e == WA3M);
    assign Match_1E_W  = (w_ra1e == WA3W);
    assign Match_2E_M  = (w_ra2e == WA3M);
    assign Match_2E_W  = (w_ra2e == WA3W);
    assign Match_3E_M  = (w_ra3e == WA3M);
    assign Match_3E_W  = (w_ra3e == WA3W);
    assign Match_12D_E = (RA1D == w_wa3e) | (RA2D == w_wa3e);

    assign MemtoRegE    = w_ctrl_e.MemtoReg;
    assign BranchTakenE = w_ctrl_e.Branch & CondExE;
    assign PCWrPendingF = PCSrcD | w_ctrl_e.PCSrc | w_pcsrc_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (FlushE && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker with a 4-bit counter build to reach saturation quickly.
module tb_hazard_tracker;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] RA1D, RA2D, RA3D, WA3D;
    logic          RegWriteD, MemtoRegD, PCSrcD, BranchD;
    logic          CondExE, StallD, FlushE;
    logic          Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W;
    logic          Match_12D_E;
    logic          RegWriteM, RegWriteW, MemtoRegE, PCSrcW, BranchTakenE, PCWrPendingF;
    logic [AW-1:0] WA3M, WA3W;
    logic [CW-1:0] StallCount, FlushCount;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA3D         (RA3D),
        .WA3D         (WA3D),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .BranchD      (BranchD),
        .CondExE      (CondExE),
        .StallD       (StallD),
        .FlushE       (FlushE),
        .Match_1E_M   (Match_1E_M),
        .Match_1E_W   (Match_1E_W),
        .Match_2E_M   (Match_2E_M),
        .Match_2E_W   (Match_2E_W),
        .Match_3E_M   (Match_3E_M),
        .Match_3E_W   (Match_3E_W),
        .Match_12D_E  (Match_12D_E),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcW       (PCSrcW),
        .BranchTakenE (BranchTakenE),
        .PCWrPendingF (PCWrPendingF),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .StallCount   (StallCount),
        .FlushCount   (FlushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RA1D = '0; RA2D = '0; RA3D = '0; WA3D = '0;
        RegWriteD = 1'b0; MemtoRegD = 1'b0; PCSrcD = 1'b0; BranchD = 1'b0;
        CondExE = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #12;
        check("rst_regwrite_m", RegWriteM, 0);
        check("rst_regwrite_w", RegWriteW, 0);
        check("rst_wa3m", WA3M, 0);
        check("rst_wa3w", WA3W, 0);
        check("rst_pending", PCWrPendingF, 0);
        check("rst_stallcnt", StallCount, 0);
        check("rst_match_1e_m", Match_1E_M, 1);
        reset = 1'b0;
        cyc();

        // Forwarding: ADD r3 then two readers of r3
        RA1D = 4'd1; RA2D = 4'd2; WA3D = 4'd3; RegWriteD = 1'b1;
        cyc();
        RA1D = 4'd3; RA2D = 4'd4; WA3D = 4'd6; RegWriteD = 1'b1; CondExE = 1'b1;
        cyc();
        check("fwd_match_1e_m", Match_1E_M, 1);
        check("fwd_match_2e_m", Match_2E_M, 0);
        check("fwd_regwrite_m", RegWriteM, 1);
        check("fwd_wa3m", WA3M, 3);
        RA1D = 4'd3; RA2D = 4'd0; WA3D = 4'd8; RegWriteD = 1'b0; CondExE = 1'b1;
        cyc();
        check("fwd_match_1e_w", Match_1E_W, 1);
        check("fwd_match_1e_m_next", Match_1E_M, 0);
        check("fwd_regwrite_w", RegWriteW, 1);
        check("fwd_wa3w", WA3W, 3);

        // Load-use stall with bubble insertion
        idle();
        cyc();
        cyc();
        RA1D = 4'd1; WA3D = 4'd5; RegWriteD = 1'b1; MemtoRegD = 1'b1;
        cyc();
        idle();
        RA1D = 4'd2; RA2D = 4'd5; CondExE = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        #1;
        check("lu_memtoreg_e", MemtoRegE, 1);
        check("lu_match_12d_e", Match_12D_E, 1);
        cyc();
        StallD = 1'b0; FlushE = 1'b0;
        #1;
        check("lu_bubble_memtoreg_e", MemtoRegE, 0);
        check("lu_match_12d_e_after", Match_12D_E, 0);
        check("lu_regwrite_m", RegWriteM, 1);
        check("lu_wa3m", WA3M, 5);
        check("lu_stallcnt", StallCount, 1);
        check("lu_flushcnt", FlushCount, 1);

        // Conditional skip
        idle();
        cyc();
        RegWriteD = 1'b1; WA3D = 4'd7;
        cyc();
        idle();
        cyc();
        check("cs_regwrite_m", RegWriteM, 0);
        check("cs_wa3m", WA3M, 7);
        cyc();
        check("cs_regwrite_w", RegWriteW, 0);
        check("cs_wa3w", WA3W, 7);

        // PC write pending window
        idle();
        CondExE = 1'b1;
        cyc();
        cyc();
        check("pc_pending_idle", PCWrPendingF, 0);
        PCSrcD = 1'b1;
        #1;
        check("pc_pending_t0", PCWrPendingF, 1);
        cyc();
        PCSrcD = 1'b0;
        #1;
        check("pc_pending_t1", PCWrPendingF, 1);
        check("pc_pcsrcw_t1", PCSrcW, 0);
        cyc();
        check("pc_pending_t2", PCWrPendingF, 1);
        check("pc_pcsrcw_t2", PCSrcW, 0);
        cyc();
        check("pc_pending_t3", PCWrPendingF, 0);
        check("pc_pcsrcw_t3", PCSrcW, 1);
        cyc();
        check("pc_pcsrcw_t4", PCSrcW, 0);

        // PC write squashed by failed condition drops one cycle early
        PCSrcD = 1'b1;
        cyc();
        PCSrcD = 1'b0; CondExE = 1'b0;
        #1;
        check("pcx_pending_e", PCWrPendingF, 1);
        cyc();
        check("pcx_pending_m", PCWrPendingF, 0);
        cyc();
        check("pcx_pcsrcw", PCSrcW, 0);

        // Branch taken / not taken
        idle();
        BranchD = 1'b1;
        cyc();
        BranchD = 1'b0; CondExE = 1'b1;
        #1;
        check("br_taken", BranchTakenE, 1);
        cyc();
        check("br_taken_one_cycle", BranchTakenE, 0);
        BranchD = 1'b1; CondExE = 1'b0;
        cyc();
        BranchD = 1'b0; CondExE = 1'b0;
        #1;
        check("br_not_taken", BranchTakenE, 0);
        CondExE = 1'b1;
        #1;
        check("br_cond_comb", BranchTakenE, 1);
        idle();

        // Counter saturation
        reset = 1'b1;
        #1;
        reset = 1'b0;
        check("sat_cnt_cleared", StallCount, 0);
        StallD = 1'b1;
        repeat (15) cyc();
        check("sat_stall_15", StallCount, 15);
        repeat (5) cyc();
        check("sat_stall_hold", StallCount, 15);
        check("sat_flush_zero", FlushCount, 0);
        StallD = 1'b0; FlushE = 1'b1;
        cyc();
        FlushE = 1'b0;
        check("sat_flush_one", FlushCount, 1);

        // Asynchronous reset mid-pipeline
        RegWriteD = 1'b1; MemtoRegD = 1'b1; PCSrcD = 1'b1; BranchD = 1'b1;
        WA3D = 4'd9; CondExE = 1'b1;
        cyc();
        cyc();
        cyc();
        check("ar_pre_regwrite_w", RegWriteW, 1);
        check("ar_pre_wa3w", WA3W, 9);
        #2;
        reset = 1'b1;
        idle();
        #1;
        check("ar_regwrite_m", RegWriteM, 0);
        check("ar_regwrite_w", RegWriteW, 0);
        check("ar_memtoreg_e", MemtoRegE, 0);
        check("ar_pcsrcw", PCSrcW, 0);
        check("ar_pending", PCWrPendingF, 0);
        check("ar_wa3m", WA3M, 0);
        check("ar_wa3w", WA3W, 0);
        check("ar_stallcnt", StallCount, 0);
        check("ar_flushcnt", FlushCount, 0);
        CondExE = 1'b1;
        #1;
        check("ar_branch_taken", BranchTakenE, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Pipeline-side counterpart of the hazard unit. It carries each instruction's register addresses and control bits from Decode through Execute, Memory and Writeback. It generates every match and pending signal the hazard unit consumes, and it applies the hazard unit's stall and flush outputs back to its own stage registers. It also keeps saturating counters of stall and flush cycles for performance debug.

## Interface
Parameters:
- `REG_AW`, default 4: register-address width (16 architectural registers).
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `RA1D`, `RA2D`, `RA3D`  in  REG_AW each  source-operand addresses of the instruction in D (RA3 is the multiply accumulate operand).
- `WA3D`  in  REG_AW  destination address in D.
- `RegWriteD`, `MemtoRegD`, `PCSrcD`, `BranchD`  in  1 each  decoded control bits.
- `CondExE`  in  1  condition check passed for the instruction in E.
- `StallD`, `FlushE`  in  1 each  from the hazard unit.
- `Match_1E_M`, `Match_1E_W`, `Match_2E_M`, `Match_2E_W`, `Match_3E_M`, `Match_3E_W`  out  1 each  operand address in E equals the destination address in M or W.
- `Match_12D_E`  out  1  `RA1D` or `RA2D` equals the destination address in E.
- `RegWriteM`, `RegWriteW`, `MemtoRegE`, `PCSrcW`, `BranchTakenE`, `PCWrPendingF`  out  1 each.
- `WA3M`, `WA3W`  out  REG_AW each  destination addresses, for writeback and forwarding muxes.
- `StallCount`, `FlushCount`  out  CNT_W each  saturating performance counters.

## Operation
- The block holds three stage registers.
- **E stage** holds `RA1E`, `RA2E`, `RA3E`, `WA3E`, `RegWriteE`, `MemtoRegE`, `PCSrcE` and `BranchE`.
  - Loads from the D inputs each cycle unless one of the cases below applies.
  - `FlushE` = 1: clear all control bits to 0. Addresses are don't-care; clear them to 0.
  - `StallD` = 1 without `FlushE`: the E register still loads. The stall freezes D only, which is external to this block.
  - `FlushE` has priority over loading.
- **M stage** holds `WA3M`, `RegWriteM`, `MemtoRegM` and `PCSrcM`.
  - Loads from E each cycle; never stalls or flushes.
  - `RegWriteM` = `RegWriteE & CondExE`; `PCSrcM` = `PCSrcE & CondExE`; `MemtoRegM` = `MemtoRegE & CondExE`.
- **W stage** holds `WA3W`, `RegWriteW` and `PCSrcW`, copied from M every cycle.
- Match outputs are combinational compares:
  - `Match_nE_M` = (`RAnE` == `WA3M`).
  - `Match_nE_W` = (`RAnE` == `WA3W`).
  - `Match_12D_E` = (`RA1D` == `WA3E`) | (`RA2D` == `WA3E`).
  - Matches are raw compares. Gating with `RegWrite`/`MemtoReg` is done downstream.
- `BranchTakenE` = `BranchE & CondExE`.
- `PCWrPendingF` = `PCSrcD | PCSrcE | PCSrcM` (combinational).
- Performance counters:
  - `StallCount` increments on each cycle with `StallD` = 1.
  - `FlushCount` increments on each cycle with `FlushE` = 1.
  - Both saturate at all-ones with no wrap.
  - When both inputs are asserted in the same cycle, both counters increment.

## Timing
- Reset (asynchronous assert, synchronous release) zeroes all stage registers and both counters.
  - Immediately after reset: every flag output is 0, `WA3M` = `WA3W` = 0, counters = 0.
  - The Match outputs evaluate to 1 while the addresses are 0 (register 0 compares equal). This is harmless because the write enables are 0.
- Latency: D inputs appear in E after 1 cycle, in M after 2 and in W after 3. Flags are registered except those derived combinationally from D or E as listed above.
- `PCWrPendingF` rises in the same cycle `PCSrcD` is asserted. It stays high for 3 cycles (D, E, M) and falls when the instruction reaches W, where `PCSrcW` is 1 for one cycle.
- If `CondExE` = 0, the instruction becomes a bubble from M onward. `PCWrPendingF` then drops one cycle early (after E).
- Reset asserted mid-operation discards all in-flight instructions at once. No partial state survives.

## Structure
- The shared package `hazard_pkg` holds:
  - the `REG_AW` default;
  - a packed typedef `stage_ctrl_t` {RegWrite, MemtoReg, PCSrc, Branch};
  - the constant `CTRL_BUBBLE` = all zeros.
- One sub-module `pipe_stage_reg`: parameterised width, `clk`/`reset`, `en`, `clr`, `d`/`q`, with `clr` taking priority. It is instantiated for E, M and W; M and W tie `en`=1 and `clr`=0.
- The counters and compares are inline in `hazard_tracker`.

## Test plan
- **Forwarding from M:** issue ADD writing R3, then SUB reading R3 as RA1. Two cycles after the ADD enters D: `Match_1E_M`=1, `RegWriteM`=1, `WA3M`=3. The next cycle: `Match_1E_W`=1.
- **Load-use stall:** LDR to R5 is in E (`MemtoRegE`=1, `WA3E`=5) while D has `RA2D`=5. Require `Match_12D_E`=1. Drive `StallD`=`FlushE`=1 for one cycle. The next cycle: `MemtoRegE`=0 and `RegWriteE`=0 (bubble), and `StallCount`=1, `FlushCount`=1.
- **Conditional skip:** `RegWriteD`=1 and `WA3D`=7 with `CondExE`=0 in the following cycle. Require `RegWriteM`=0 and then `RegWriteW`=0.
- **PC write:** `PCSrcD`=1 at cycle t. Require `PCWrPendingF`=1 in cycles t..t+2, `PCSrcW`=1 at t+3 only, and `PCWrPendingF`=0 at t+3.
- **Branch taken:** `BranchD`=1, then `CondExE`=1. Require `BranchTakenE`=1 for exactly one cycle. With `CondExE`=0, `BranchTakenE` stays 0.
- **Saturation and reset:** with `CNT_W`=4, hold `StallD`=1 for 20 cycles, then require `StallCount`=15. Assert `reset` asynchronously mid-pipeline; in the same cycle all flags and counters read 0.
